// File: rtl/mips_pkg.sv
// Shared encodings for the single-cycle MIPS control path: ALU operation codes,
// primary opcodes and R-type function codes. Used by the ALU-control decoder and
// by the main control decoder.
package mips_pkg;

  // ALU operation codes (4'b1110 and 4'b1111 are reserved and never produced)
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_ADDS = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_SUBS = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_NOR  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_SLL  = 4'b1010;
  localparam logic [3:0] ALU_SRL  = 4'b1011;
  localparam logic [3:0] ALU_SRA  = 4'b1100;
  localparam logic [3:0] ALU_LUI  = 4'b1101;

  // Primary opcodes, instruction[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes, instruction[5:0]
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_SLLV  = 6'b000100;
  localparam logic [5:0] FN_SRLV  = 6'b000110;
  localparam logic [5:0] FN_SRAV  = 6'b000111;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;

endpackage

// File: rtl/alu_ctr.sv
// ALU-control decoder: maps opcode and R-type function field to the 4-bit ALU
// operation code. Combinational outputs feed the single-cycle datapath; a
// registered copy (one cycle later, no enable) feeds pipelined/debug consumers.
module alu_ctr
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] func,
  output logic [3:0] ALUctr,
  output logic       shift_var,
  output logic       illegal,
  output logic [3:0] ALUctr_q,
  output logic       illegal_q
);

  // Decode op/func; unknown pairs fall back to ADD with illegal raised
  always_comb begin
    ALUctr    = ALU_ADD;
    shift_var = 1'b0;
    illegal   = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (func)
          FN_ADDU: ALUctr = ALU_ADD;
          FN_ADD:  ALUctr = ALU_ADDS;
          FN_SUBU: ALUctr = ALU_SUB;
          FN_SUB:  ALUctr = ALU_SUBS;
          FN_AND:  ALUctr = ALU_AND;
          FN_OR:   ALUctr = ALU_OR;
          FN_XOR:  ALUctr = ALU_XOR;
          FN_NOR:  ALUctr = ALU_NOR;
          FN_SLT:  ALUctr = ALU_SLT;
          FN_SLTU: ALUctr = ALU_SLTU;
          FN_SLL:  ALUctr = ALU_SLL;
          FN_SRL:  ALUctr = ALU_SRL;
          FN_SRA:  ALUctr = ALU_SRA;
          FN_SLLV: begin
            ALUctr    = ALU_SLL;
            shift_var = 1'b1;
          end
          FN_SRLV: begin
            ALUctr    = ALU_SRL;
            shift_var = 1'b1;
          end
          FN_SRAV: begin
            ALUctr    = ALU_SRA;
            shift_var = 1'b1;
          end
          // jr only needs the ALU to pass rs; ADD is harmless
          FN_JR:   ALUctr = ALU_ADD;
          default: illegal = 1'b1;
        endcase
      end
      OP_ADDIU: ALUctr = ALU_ADD;
      OP_ADDI:  ALUctr = ALU_ADDS;
      OP_ANDI:  ALUctr = ALU_AND;
      OP_ORI:   ALUctr = ALU_OR;
      OP_XORI:  ALUctr = ALU_XOR;
      OP_SLTI:  ALUctr = ALU_SLT;
      OP_SLTIU: ALUctr = ALU_SLTU;
      OP_LUI:   ALUctr = ALU_LUI;
      OP_LW:    ALUctr = ALU_ADD;
      OP_SW:    ALUctr = ALU_ADD;
      // branches compare by subtraction
      OP_BEQ:   ALUctr = ALU_SUB;
      OP_BNE:   ALUctr = ALU_SUB;
      OP_J:     ALUctr = ALU_ADD;
      OP_JAL:   ALUctr = ALU_ADD;
      default:  illegal = 1'b1;
    endcase
  end

  // One-cycle registered copy of the decode, cleared asynchronously by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ALUctr_q  <= ALU_ADD;
      illegal_q <= 1'b0;
    end else begin
      ALUctr_q  <= ALUctr;
      illegal_q <= illegal;
    end
  end

endmodule

// File: tb/tb_alu_ctr.sv
// Directed self-checking bench for alu_ctr.
module tb_alu_ctr;

  logic       clk;
  logic       rst_n;
  logic [5:0] op;
  logic [5:0] func;
  logic [3:0] ALUctr;
  logic       shift_var;
  logic       illegal;
  logic [3:0] ALUctr_q;
  logic       illegal_q;

  int errors = 0;
  int checks = 0;

  alu_ctr dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op        (op),
    .func      (func),
    .ALUctr    (ALUctr),
    .shift_var (shift_var),
    .illegal   (illegal),
    .ALUctr_q  (ALUctr_q),
    .illegal_q (illegal_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-written decode tables
  logic [5:0] r_fn  [17] = '{6'h21, 6'h20, 6'h23, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27,
                             6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08};
  logic [3:0] r_exp [17] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
                             4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hA, 4'hB, 4'hC, 4'h0};
  logic       r_sv  [17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                             1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [5:0] i_op  [14] = '{6'h09, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0A, 6'h0B, 6'h0F,
                             6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};
  logic [3:0] i_exp [14] = '{4'h0, 4'h1, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hD,
                             4'h0, 4'h0, 4'h2, 4'h2, 4'h0, 4'h0};

  // Per-cycle sequence for the latency test
  logic [5:0] s_op  [5] = '{6'h00, 6'h0F, 6'h00, 6'h04, 6'h00};
  logic [5:0] s_fn  [5] = '{6'h20, 6'h3F, 6'h07, 6'h00, 6'h2B};
  logic [3:0] s_exp [5] = '{4'h1, 4'hD, 4'hC, 4'h2, 4'h9};

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference lookup from the tables above: returns legality, code and shift_var
  task automatic ref_decode(input logic [5:0] o, input logic [5:0] f,
                            output logic legal, output logic [3:0] code, output logic sv);
    legal = 1'b0;
    code  = 4'h0;
    sv    = 1'b0;
    if (o == 6'h00) begin
      for (int k = 0; k < 17; k++)
        if (r_fn[k] == f) begin
          legal = 1'b1;
          code  = r_exp[k];
          sv    = r_sv[k];
        end
    end else begin
      for (int k = 0; k < 14; k++)
        if (i_op[k] == o) begin
          legal = 1'b1;
          code  = i_exp[k];
        end
    end
  endtask

  initial begin
    logic       legal;
    logic [3:0] code;
    logic       sv;
    int         bad_x;
    int         bad_rsv;
    int         bad_dec;

    // 1. reset behaviour
    rst_n = 1'b0;
    op    = 6'h00;
    func  = 6'h20;
    #1;
    check("rst_comb_aluctr", {4'h0, ALUctr}, 8'h01);
    check("rst_aluctr_q", {4'h0, ALUctr_q}, 8'h00);
    check("rst_illegal_q", {7'h0, illegal_q}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_aluctr_q", {4'h0, ALUctr_q}, 8'h01);

    // 2. R-type sweep
    op = 6'h00;
    for (int i = 0; i < 17; i++) begin
      func = r_fn[i];
      #1;
      check($sformatf("rtype_aluctr_fn%02h", r_fn[i]), {4'h0, ALUctr}, {4'h0, r_exp[i]});
      check($sformatf("rtype_shiftvar_fn%02h", r_fn[i]), {7'h0, shift_var}, {7'h0, r_sv[i]});
      check($sformatf("rtype_illegal_fn%02h", r_fn[i]), {7'h0, illegal}, 8'h00);
    end

    // 3. I/J sweep with garbage func
    func = 6'h3F;
    for (int i = 0; i < 14; i++) begin
      op = i_op[i];
      #1;
      check($sformatf("ij_aluctr_op%02h", i_op[i]), {4'h0, ALUctr}, {4'h0, i_exp[i]});
      check($sformatf("ij_illegal_op%02h", i_op[i]), {7'h0, illegal}, 8'h00);
      check($sformatf("ij_shiftvar_op%02h", i_op[i]), {7'h0, shift_var}, 8'h00);
    end

    // 4. illegal encodings
    @(posedge clk);
    #1;
    op   = 6'h00;
    func = 6'h2F;
    #1;
    check("ill_rfn_aluctr", {4'h0, ALUctr}, 8'h00);
    check("ill_rfn_illegal", {7'h0, illegal}, 8'h01);
    @(posedge clk);
    #1;
    check("ill_rfn_illegal_q", {7'h0, illegal_q}, 8'h01);
    op   = 6'h3F;
    func = 6'h20;
    #1;
    check("ill_op_aluctr", {4'h0, ALUctr}, 8'h00);
    check("ill_op_illegal", {7'h0, illegal}, 8'h01);
    @(posedge clk);
    #1;
    check("ill_op_illegal_q", {7'h0, illegal_q}, 8'h01);
    check("ill_op_aluctr_q", {4'h0, ALUctr_q}, 8'h00);

    // 5. one-cycle latency, then asynchronous reset between edges
    for (int i = 0; i < 5; i++) begin
      op   = s_op[i];
      func = s_fn[i];
      #1;
      if (i > 0)
        check($sformatf("lat_hold_%0d", i), {4'h0, ALUctr_q}, {4'h0, s_exp[i-1]});
      check($sformatf("lat_comb_%0d", i), {4'h0, ALUctr}, {4'h0, s_exp[i]});
      @(posedge clk);
      #1;
      check($sformatf("lat_q_%0d", i), {4'h0, ALUctr_q}, {4'h0, s_exp[i]});
      check($sformatf("lat_illq_%0d", i), {7'h0, illegal_q}, 8'h00);
    end
    op   = 6'h3F;
    func = 6'h00;
    @(posedge clk);
    #1;
    check("pre_arst_illegal_q", {7'h0, illegal_q}, 8'h01);
    op   = 6'h00;
    func = 6'h07;
    @(posedge clk);
    #2;
    check("pre_arst_aluctr_q", {4'h0, ALUctr_q}, 8'h0C);
    rst_n = 1'b0;
    #1;
    check("arst_aluctr_q", {4'h0, ALUctr_q}, 8'h00);
    check("arst_illegal_q", {7'h0, illegal_q}, 8'h00);
    check("arst_comb_aluctr", {4'h0, ALUctr}, 8'h0C);
    check("arst_comb_shiftvar", {7'h0, shift_var}, 8'h01);
    @(posedge clk);
    #1;
    check("arst_hold_aluctr_q", {4'h0, ALUctr_q}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // 6. exhaustive op/func space
    bad_x   = 0;
    bad_rsv = 0;
    bad_dec = 0;
    for (int o = 0; o < 64; o++) begin
      for (int f = 0; f < 64; f++) begin
        op   = o[5:0];
        func = f[5:0];
        #1;
        if ((^{ALUctr, shift_var, illegal, ALUctr_q, illegal_q}) === 1'bx) bad_x++;
        if (ALUctr == 4'hE || ALUctr == 4'hF) bad_rsv++;
        ref_decode(o[5:0], f[5:0], legal, code, sv);
        if (illegal !== !legal || ALUctr !== code || shift_var !== sv) bad_dec++;
      end
    end
    check("exh_no_x", bad_x[7:0], 8'h00);
    check("exh_no_reserved", bad_rsv[7:0], 8'h00);
    check("exh_decode_mismatches", (bad_dec > 255) ? 8'hFF : bad_dec[7:0], 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
